reg_file_sequencer: RTL

Sequences all accesses to the 16×16-bit register file for one Hmmm instruction: operand reads of rs and rt, then a write-back to rd over the shared tri-state data bus. Sits between the instruction decoder/ALU and the register file. It drives register_select, reg_file_in and reg_file_out, and owns the bus during write-back. Enforces the Hmmm rule that r0 reads as zero and is never written.

---
 rtl/reg_file_sequencer_if.sv | 31 +++
 rtl/reg_file_sequencer.sv | 118 +++++++++++
 2 files changed

// File: rtl/reg_file_sequencer_if.sv
// Handshake bundle between the decoder/ALU and the register-file sequencer,
// including the register-file control strobes.
interface reg_file_sequencer_if;
  logic        start;
  logic [3:0]  rs;
  logic [3:0]  rt;
  logic [3:0]  rd;
  logic        rs_en;
  logic        rt_en;
  logic        rd_en;
  logic        wb_valid;
  logic [15:0] wb_data;
  logic        busy;
  logic        ops_valid;
  logic [15:0] opa;
  logic [15:0] opb;
  logic        done;
  logic [3:0]  register_select;
  logic        reg_file_out;
  logic        reg_file_in;

  modport master (
    output start, rs, rt, rd, rs_en, rt_en, rd_en, wb_valid, wb_data,
    input  busy, ops_valid, opa, opb, done, register_select, reg_file_out, reg_file_in
  );

  modport slave (
    input  start, rs, rt, rd, rs_en, rt_en, rd_en, wb_valid, wb_data,
    output busy, ops_valid, opa, opb, done, register_select, reg_file_out, reg_file_in
  );
endinterface

// File: rtl/reg_file_sequencer.sv
// Sequences rs/rt operand reads and the rd write-back for one Hmmm instruction
// over the shared register bus; r0 reads as zero and is never written.
module reg_file_sequencer (
  input  logic                 clk,
  input  logic                 rst,
  reg_file_sequencer_if.slave  bus,
  inout  wire  [15:0]          data
);

  typedef enum logic [2:0] {IDLE, RD_A, RD_B, WAIT_WB, WR, DONE} state_t;

  state_t      r_state;
  state_t      w_nxt;
  logic [3:0]  r_rs, r_rt, r_rd;
  logic        r_rs_en, r_rt_en, r_rd_en;
  logic [15:0] r_opa, r_opb, r_wb;
  logic        r_busy, r_done, r_ops_valid;
  logic        r_rfo, r_rfi, r_drv;
  logic [3:0]  r_sel;

  logic        w_accept;
  logic [3:0]  w_rs, w_rt, w_rd;
  logic        w_rs_en, w_rt_en, w_rd_en;
  logic [3:0]  w_sel;

  // Fields seen by next-state/output logic: live inputs on the accepting
  // edge, latched copies for the rest of the request.
  always_comb begin
    w_accept = ((r_state == IDLE) || (r_state == DONE)) && bus.start;
    w_rs     = w_accept ? bus.rs    : r_rs;
    w_rt     = w_accept ? bus.rt    : r_rt;
    w_rd     = w_accept ? bus.rd    : r_rd;
    w_rs_en  = w_accept ? bus.rs_en : r_rs_en;
    w_rt_en  = w_accept ? bus.rt_en : r_rt_en;
    w_rd_en  = w_accept ? bus.rd_en : r_rd_en;
    w_nxt    = r_state;
    case (r_state)
      IDLE, DONE: begin
        if (w_accept)
          w_nxt = w_rs_en ? RD_A : w_rt_en ? RD_B : w_rd_en ? WAIT_WB : DONE;
        else
          w_nxt = IDLE;
      end
      RD_A:    w_nxt = w_rt_en ? RD_B : w_rd_en ? WAIT_WB : DONE;
      RD_B:    w_nxt = w_rd_en ? WAIT_WB : DONE;
      WAIT_WB: w_nxt = bus.wb_valid ? WR : WAIT_WB;
      WR:      w_nxt = DONE;
      default: w_nxt = IDLE;
    endcase
    case (w_nxt)
      RD_A:    w_sel = w_rs;
      RD_B:    w_sel = w_rt;
      WR:      w_sel = w_rd;
      default: w_sel = 4'd0;
    endcase
  end

  // Outputs are registered against the next state so they line up with the
  // state they describe and have no combinational path from inputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_rs        <= '0;
      r_rt        <= '0;
      r_rd        <= '0;
      r_rs_en     <= 1'b0;
      r_rt_en     <= 1'b0;
      r_rd_en     <= 1'b0;
      r_opa       <= '0;
      r_opb       <= '0;
      r_wb        <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_ops_valid <= 1'b0;
      r_rfo       <= 1'b0;
      r_rfi       <= 1'b0;
      r_drv       <= 1'b0;
      r_sel       <= '0;
    end else begin
      r_state <= w_nxt;
      if (w_accept) begin
        r_rs    <= bus.rs;
        r_rt    <= bus.rt;
        r_rd    <= bus.rd;
        r_rs_en <= bus.rs_en;
        r_rt_en <= bus.rt_en;
        r_rd_en <= bus.rd_en;
      end
      case (r_state)
        RD_A:    r_opa <= (r_rs == 4'd0) ? 16'd0 : data;
        RD_B:    r_opb <= (r_rt == 4'd0) ? 16'd0 : data;
        WAIT_WB: if (bus.wb_valid) r_wb <= bus.wb_data;
        default: ;
      endcase
      r_busy      <= (w_nxt != IDLE) && (w_nxt != DONE);
      r_done      <= (w_nxt == DONE);
      r_ops_valid <= (w_nxt == WAIT_WB);
      r_rfo       <= ((w_nxt == RD_A) && (w_rs != 4'd0)) ||
                     ((w_nxt == RD_B) && (w_rt != 4'd0));
      r_rfi       <= (w_nxt == WR) && (w_rd != 4'd0);
      r_drv       <= (w_nxt == WR);
      r_sel       <= w_sel;
    end
  end

  // The bus is still driven in WR when rd=0; only the write strobe is held off.
  assign data = r_drv ? r_wb : 16'hzzzz;

  assign bus.busy            = r_busy;
  assign bus.done            = r_done;
  assign bus.ops_valid       = r_ops_valid;
  assign bus.opa             = r_opa;
  assign bus.opb             = r_opb;
  assign bus.register_select = r_sel;
  assign bus.reg_file_out    = r_rfo;
  assign bus.reg_file_in     = r_rfi;

endmodule
